// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter giving a fetch port and a loader port shared access to a
// byte-wide instruction memory; each 32-bit word moves as four big-endian byte beats.
module instr_mem_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_ack,
  output logic [31:0]   f_data,
  input  logic          l_req,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ack,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  state_t        state, state_nxt;
  logic          gnt_l;
  logic          last_l;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    beat;
  logic [31:0]   rd_word;
  logic [31:0]   rd_word_nxt;

  logic          f_bad, l_bad;
  logic          pick_l;
  logic          sel_bad;
  logic          going_resp;
  logic          resp_l;
  logic          resp_bad;

  // A word is illegal when misaligned or when its last byte would fall past the end.
  assign f_bad   = (f_addr[1:0] != 2'b00) || (f_addr > ADDR_MAX);
  assign l_bad   = (l_addr[1:0] != 2'b00) || (l_addr > ADDR_MAX);
  assign pick_l  = l_req && (!f_req || !last_l);
  assign sel_bad = pick_l ? l_bad : f_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (f_req || l_req) begin
          state_nxt = sel_bad ? RESP : XFER;
        end
      end
      XFER: begin
        if (beat == 2'd3) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant side and error status as they will be in RESP, valid on the edge entering it.
  assign going_resp = (state != RESP) && (state_nxt == RESP);
  assign resp_l     = (state == IDLE) ? pick_l  : gnt_l;
  assign resp_bad   = (state == IDLE) ? sel_bad : 1'b0;

  always_comb begin
    rd_word_nxt = rd_word;
    case (beat)
      2'd0:    rd_word_nxt[31:24] = mem_rdata;
      2'd1:    rd_word_nxt[23:16] = mem_rdata;
      2'd2:    rd_word_nxt[15:8]  = mem_rdata;
      default: rd_word_nxt[7:0]   = mem_rdata;
    endcase
  end

  always_comb begin
    mem_wdata = 8'h00;
    case (beat)
      2'd0:    mem_wdata = wdata_q[31:24];
      2'd1:    mem_wdata = wdata_q[23:16];
      2'd2:    mem_wdata = wdata_q[15:8];
      default: mem_wdata = wdata_q[7:0];
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_we   = (state == XFER) && gnt_l;
  assign mem_addr = (state == XFER) ? (addr_q + AW'(beat)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_l   <= 1'b0;
      last_l  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      beat    <= 2'd0;
      rd_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (f_req || l_req) begin
            gnt_l  <= pick_l;
            last_l <= pick_l;
            addr_q <= pick_l ? l_addr[AW-1:0] : f_addr[AW-1:0];
            beat   <= 2'd0;
            if (pick_l) begin
              wdata_q <= l_wdata;
            end
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (!gnt_l) begin
            rd_word <= rd_word_nxt;
          end
        end
        default: beat <= 2'd0;
      endcase
    end
  end

  // Completion outputs are registered so the ack is a clean single-cycle pulse in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_ack  <= 1'b0;
      l_ack  <= 1'b0;
      err    <= 1'b0;
      f_data <= '0;
    end else begin
      f_ack <= going_resp && !resp_l;
      l_ack <= going_resp && resp_l;
      err   <= going_resp && resp_bad;
      if (going_resp && !resp_l) begin
        f_data <= resp_bad ? 32'h0 : rd_word_nxt;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Scoreboard bench for instr_mem_arbiter: a transaction-level model predicts each
// ack (kind, data, err, cycle); a monitor pops and compares whenever an ack appears.
module tb_instr_mem_arbiter;
  localparam int MB = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, l_req;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_ack, l_ack, err, mem_we, busy;
  logic [31:0]   f_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  instr_mem_arbiter #(.MEM_BYTES(MB), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .err(err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      4: return 8'h00;
      5: return 8'hF0;
      6: return 8'h00;
      7: return 8'h93;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];
  bit mem_ready = 1'b0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MB; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  typedef struct {
    bit          is_l;
    logic [31:0] data;
    bit          err;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];
  bit   last_l_m;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a > MB - 4);
  endfunction

  // Model: grants in order, memory as a byte array, latency from the
  // "sample edge / 4 beats / RESP / one idle cycle" timing rules.
  task automatic run(input bit fe, input logic [31:0] fa, input bit le,
                     input logic [31:0] la, input logic [31:0] lw,
                     input int n, input bit drop);
    int  s;
    int  start;
    int  acks;
    int  budget;
    bit  who;
    exp_t e;
    start = cyc;
    s = cyc + 1;
    for (int k = 0; k < n; k++) begin
      who = (fe && le) ? !last_l_m : le;
      last_l_m = who;
      e.is_l = who;
      e.data = 32'h0;
      if (who) begin
        e.err = bad_addr(la);
        if (!e.err) for (int b = 0; b < 4; b++) ref_mem[int'(la) + b] = lw[31 - 8*b -: 8];
      end else begin
        e.err = bad_addr(fa);
        if (!e.err) for (int b = 0; b < 4; b++) e.data[31 - 8*b -: 8] = ref_mem[int'(fa) + b];
      end
      e.ack_cyc = s + (e.err ? 0 : 4);
      s = e.ack_cyc + 2;
      sb.push_back(e);
    end
    f_req = fe; f_addr = fa; l_req = le; l_addr = la; l_wdata = lw;
    acks = 0;
    budget = 0;
    while (acks < n) begin
      @(negedge clk);
      budget++;
      if (f_ack || l_ack) acks++;
      if (drop && cyc == start + 3) begin
        f_req = 1'b0; l_req = 1'b0;
        f_addr = $urandom; l_addr = $urandom; l_wdata = $urandom;
      end
      if (budget > 12 * n + 10) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_timeout: got %0d acks expected %0d", acks, n);
        finish_run();
      end
    end
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, MB/4 - 1)) * 4;
    if (r == 7) return 32'($urandom_range(0, MB - 1)) | 32'd1;
    if (r == 8) return 32'(MB + 4 * $urandom_range(0, 3));
    return $urandom | 32'h8000_0000;
  endfunction

  exp_t        m_e;
  logic [31:0] exp_fd = 32'h0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_fd = 32'h0;
      wcnt = 0;
    end else begin
      if (mem_we) wcnt++;
      if (f_ack || l_ack) begin
        if (f_ack && l_ack) begin
          n_cmp++; n_bad++;
          $display("FAIL both_acks: got f_ack=1 l_ack=1 expected one");
        end
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: got f_ack=%0b l_ack=%0b expected none", f_ack, l_ack);
        end else begin
          m_e = sb.pop_front();
          check("ack_kind", 32'(l_ack), 32'(m_e.is_l));
          check("err", 32'(err), 32'(m_e.err));
          check("ack_cycle", 32'(cyc), 32'(m_e.ack_cyc));
          check("busy_in_resp", 32'(busy), 32'd1);
          check("write_beats", 32'(wcnt), (m_e.is_l && !m_e.err) ? 32'd4 : 32'd0);
          if (!m_e.is_l) begin
            check("f_data", f_data, m_e.data);
            exp_fd = m_e.data;
          end
        end
        wcnt = 0;
      end else begin
        check("f_data_hold", f_data, exp_fd);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; l_req = 1'b0;
    last_l_m = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start;
    reset = 1'b1;
    f_req = 1'b0; l_req = 1'b0;
    f_addr = '0; l_addr = '0; l_wdata = '0;
    last_l_m = 1'b1;
    for (int i = 0; i < MB; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    check("rst_f_ack", 32'(f_ack), 32'd0);
    check("rst_l_ack", 32'(l_ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_f_data", f_data, 32'd0);

    // Request raised together with reset release: sampled on the very next edge.
    reset = 1'b0;
    run(1, 32'd4, 0, 0, 0, 1, 0);
    run(0, 0, 1, 32'd8, 32'h03A0C113, 1, 0);
    check("mem_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'h03A0C113);
    run(1, 32'd8, 0, 0, 0, 1, 0);
    check("fetch_8_word", f_data, 32'h03A0C113);

    do_reset();
    run(1, 32'd16, 1, 32'd20, 32'h1234_5678, 4, 0);

    run(1, 32'd6, 0, 0, 0, 1, 0);
    run(0, 0, 1, 32'd128, 32'hDEAD_BEEF, 1, 0);
    run(1, 32'd124, 0, 0, 0, 1, 0);
    run(0, 0, 1, 32'd125, 32'h0BAD_0BAD, 1, 0);
    run(1, 32'hFFFF_FFFC, 1, 32'd126, 32'h5555_AAAA, 2, 0);

    // Reset during loader beat 2 at address 12.
    start = cyc;
    l_req = 1'b1; l_addr = 32'd12; l_wdata = 32'hAABBCCDD;
    repeat (3) @(negedge clk);
    check("rst_beat2_cycle", 32'(cyc), 32'(start + 3));
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_l_ack", 32'(l_ack), 32'd0);
    check("midrst_f_data", f_data, 32'd0);
    l_req = 1'b0;
    last_l_m = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_mem[12] = 8'hAA;
    ref_mem[13] = 8'hBB;
    check("midrst_b12_13", {16'h0, mem[12], mem[13]}, 32'h0000AABB);
    check("midrst_b14_15", {16'h0, mem[14], mem[15]}, {16'h0, init_byte(14), init_byte(15)});
    run(1, 32'd0, 1, 32'd32, 32'hCAFE_F00D, 2, 0);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: run(1, rand_addr(), 0, 0, 0, 1, 0);
        1: run(0, 0, 1, rand_addr(), $urandom, 1, 0);
        2: run(1, rand_addr(), 1, rand_addr(), $urandom, 2, 0);
        default: begin
          if ($urandom_range(0, 1) == 0) run(1, rand_addr(), 0, 0, 0, 1, 1);
          else run(0, 0, 1, rand_addr(), $urandom, 1, 1);
        end
      endcase
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < MB; i++) check($sformatf("mem_byte_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
    finish_run();
  end

endmodule
